// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the program-counter / instruction-fetch sequencer.
`timescale 1ns/1ps
package fetch_ctrl_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Address the PC holds after a CLEAR pulse.
    localparam logic [15:0] RESET_VEC = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SETTLE,
        ST_FETCH,
        ST_HOLD,
        ST_ADVANCE,
        ST_HALT,
        ST_FAULT
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fetch_ctrl_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
`timescale 1ns/1ps
module fetch_ctrl_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// PC / instruction-fetch sequencer for the 16-bit CPU.
// Optional ROM watchdog enabled by defining FETCH_CTRL_TIMEOUT_EN.
//
//   state   | meaning
//   IDLE    | stopped after reset, waiting for run or restart
//   CLEAR   | one-cycle pulse of pc_load+pc_inc, clears PC to 0
//   SETTLE  | waiting SETTLE_CYC cycles for pc_addr to become valid
//   FETCH   | rom_req high until rom_ack
//   HOLD    | ir_valid high until decode takes it
//   ADVANCE | one-cycle pc_load (branch) or pc_inc pulse
//   HALT    | stopped at an instruction boundary, PC settled
//   FAULT   | ROM never answered; only reset leaves
`timescale 1ns/1ps
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          ADDR_W      = ADDR_W_DEF,
    parameter int          DATA_W      = DATA_W_DEF,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              halt_req,
    input  logic              restart,
    input  logic [ADDR_W-1:0] pc_addr,
    output logic              pc_load,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] pc_target,
    output logic              rom_req,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    output logic              halted,
    output logic              busy,
    output logic              fault
);

    // One timer serves both the settle wait and the FETCH watchdog, so it is
    // sized for the larger of the two.
    localparam int unsigned TMR_MAX = max_u(SETTLE_CYC, TIMEOUT_CYC);
    localparam int          TMR_W   = $clog2(TMR_MAX + 1);

    state_t             state, state_next;
    logic               restart_pend;
    logic               pend_any;
    logic               br_sel;
    logic               fetch_enter;
    logic               ir_capture;
    logic               ir_take;
    logic               tmr_load;
    logic               tmr_en;
    logic               tmr_done;
    logic [TMR_W-1:0]   tmr_val;

    // A restart seen this very cycle counts the same as one already latched.
    assign pend_any = restart_pend | restart;

    fetch_ctrl_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    // Next-state and Moore outputs.
    always_comb begin
        state_next = state;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        rom_req    = 1'b0;
        ir_valid   = 1'b0;
        halted     = 1'b0;
        busy       = 1'b1;
        tmr_en     = 1'b0;
        ir_capture = 1'b0;
        ir_take    = 1'b0;

        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (run || restart) state_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                pc_load    = 1'b1;
                pc_inc     = 1'b1;
                state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    if (pend_any)      state_next = ST_CLEAR;
                    else if (halt_req) state_next = ST_HALT;
                    else               state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rom_req = 1'b1;
                tmr_en  = 1'b1;
                if (rom_ack) begin
                    // A restart never abandons the read; it only drops the data.
                    if (pend_any) begin
                        state_next = ST_CLEAR;
                    end else begin
                        ir_capture = 1'b1;
                        state_next = ST_HOLD;
                    end
                end
`ifdef FETCH_CTRL_TIMEOUT_EN
                else if (tmr_done) begin
                    state_next = ST_FAULT;
                end
`endif
            end
            ST_HOLD: begin
                ir_valid = 1'b1;
                if (restart) begin
                    state_next = ST_CLEAR;
                end else if (ir_ready) begin
                    ir_take    = 1'b1;
                    state_next = ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                pc_load    = br_sel;
                pc_inc     = ~br_sel;
                state_next = ST_SETTLE;
            end
            ST_HALT: begin
                halted = 1'b1;
                busy   = 1'b0;
                if (pend_any)               state_next = ST_CLEAR;
                else if (run && !halt_req)  state_next = ST_FETCH;
            end
            ST_FAULT: begin
                state_next = ST_FAULT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Timer is reloaded on every entry into SETTLE or FETCH.
    always_comb begin
        fetch_enter = (state_next == ST_FETCH) && (state != ST_FETCH);
        tmr_load    = fetch_enter ||
                      ((state_next == ST_SETTLE) && (state != ST_SETTLE));
        tmr_val     = (state_next == ST_SETTLE) ? TMR_W'(SETTLE_CYC - 1)
                                                : TMR_W'(TIMEOUT_CYC - 1);
    end

    // State, restart flag and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            restart_pend <= 1'b0;
            rom_addr     <= '0;
            ir           <= '0;
            ir_pc        <= '0;
            pc_target    <= ADDR_W'(RESET_VEC);
            br_sel       <= 1'b0;
        end else begin
            state <= state_next;

            if (state_next == ST_CLEAR)
                restart_pend <= 1'b0;
            else if (restart && (state != ST_IDLE))
                restart_pend <= 1'b1;

            if (fetch_enter)
                rom_addr <= pc_addr;

            if (ir_capture) begin
                ir    <= rom_data;
                ir_pc <= rom_addr;
            end

            if (ir_take) begin
                br_sel <= br_valid;
                if (br_valid) pc_target <= br_target;
            end
        end
    end

`ifdef FETCH_CTRL_TIMEOUT_EN
    assign fault = (state == ST_FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a cycle table for start-up and a branch,
// then hand-written sequences for backpressure, wrap, restart and halt.
`timescale 1ns/1ps
module tb_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run, halt_req, restart;
    logic [15:0] pc_addr;
    logic        pc_load, pc_inc;
    logic [15:0] pc_target;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [15:0] ir, ir_pc;
    logic        ir_valid, ir_ready;
    logic        br_valid;
    logic [15:0] br_target;
    logic        halted, busy, fault;

    int n_cmp = 0;
    int n_err = 0;

    fetch_ctrl dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req), .restart(restart),
        .pc_addr(pc_addr), .pc_load(pc_load), .pc_inc(pc_inc), .pc_target(pc_target),
        .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack), .rom_data(rom_data),
        .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .br_valid(br_valid), .br_target(br_target),
        .halted(halted), .busy(busy), .fault(fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC model
    logic [15:0] pc_model;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                pc_model <= 16'h1234;
        else if (pc_load && pc_inc) pc_model <= 16'h0000;
        else if (pc_load)          pc_model <= pc_target;
        else if (pc_inc)           pc_model <= pc_model + 16'h0001;
    end
    assign pc_addr = pc_model;

    // ROM model: ack after ack_delay wait cycles, data derived from address
    logic ack_en;
    int   ack_delay;
    int   wait_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  wait_cnt <= 0;
        else if (rom_req && !rom_ack) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end
    assign rom_ack  = rom_req && ack_en && (wait_cnt >= ack_delay);
    assign rom_data = rom_addr ^ 16'hBEEF;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic logic cond_of(input int which);
        case (which)
            0:       return rom_req;
            1:       return ir_valid;
            default: return halted;
        endcase
    endfunction

    task automatic wait_on(input int which, input int max, input string nm);
        int n;
        n = 0;
        while (cond_of(which) !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        if (cond_of(which) !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: timeout after %0d cycles, got 0, expected 1", nm, max);
        end
    endtask

    typedef struct {
        logic        bv;
        logic [15:0] bt;
        logic        rreq;
        logic [15:0] raddr;
        logic        pld;
        logic        pinc;
        logic        irv;
        logic [15:0] irpc;
        logic        bsy;
        logic [15:0] ptgt;
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic bv, input logic [15:0] bt, input logic rreq,
                                input logic [15:0] raddr, input logic pld, input logic pinc,
                                input logic irv, input logic [15:0] irpc, input logic bsy,
                                input logic [15:0] ptgt);
        vec_t v;
        v.bv = bv; v.bt = bt; v.rreq = rreq; v.raddr = raddr; v.pld = pld;
        v.pinc = pinc; v.irv = irv; v.irpc = irpc; v.bsy = bsy; v.ptgt = ptgt;
        return v;
    endfunction

    initial begin
        int g, rq, n_inc, n_ld;

        //            bv  bt       rreq raddr   pld pinc irv irpc    bsy ptgt
        tbl[0]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0000); // IDLE
        tbl[1]  = mk(0, 16'h0000, 0, 16'h0000, 1, 1, 0, 16'h0000, 1, 16'h0000); // CLEAR
        tbl[2]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0000);
        tbl[3]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0000);
        tbl[4]  = mk(0, 16'h0000, 1, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0000); // FETCH 0
        tbl[5]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 1, 16'h0000, 1, 16'h0000); // HOLD
        tbl[6]  = mk(0, 16'h0000, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0000); // ADVANCE
        tbl[7]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0000);
        tbl[8]  = mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 16'h0000);
        tbl[9]  = mk(0, 16'h0000, 1, 16'h0001, 0, 0, 0, 16'h0000, 1, 16'h0000); // FETCH 1
        tbl[10] = mk(0, 16'h0000, 0, 16'h0001, 0, 0, 1, 16'h0001, 1, 16'h0000);
        tbl[11] = mk(0, 16'h0000, 0, 16'h0001, 0, 1, 0, 16'h0001, 1, 16'h0000);
        tbl[12] = mk(0, 16'h0000, 0, 16'h0001, 0, 0, 0, 16'h0001, 1, 16'h0000);
        tbl[13] = mk(0, 16'h0000, 0, 16'h0001, 0, 0, 0, 16'h0001, 1, 16'h0000);
        tbl[14] = mk(0, 16'h0000, 1, 16'h0002, 0, 0, 0, 16'h0001, 1, 16'h0000); // FETCH 2
        tbl[15] = mk(0, 16'h0000, 0, 16'h0002, 0, 0, 1, 16'h0002, 1, 16'h0000);
        tbl[16] = mk(0, 16'h0000, 0, 16'h0002, 0, 1, 0, 16'h0002, 1, 16'h0000);
        tbl[17] = mk(0, 16'h0000, 0, 16'h0002, 0, 0, 0, 16'h0002, 1, 16'h0000);
        tbl[18] = mk(0, 16'h0000, 0, 16'h0002, 0, 0, 0, 16'h0002, 1, 16'h0000);
        tbl[19] = mk(0, 16'h0000, 1, 16'h0003, 0, 0, 0, 16'h0002, 1, 16'h0000); // FETCH 3
        tbl[20] = mk(1, 16'h0100, 0, 16'h0003, 0, 0, 1, 16'h0003, 1, 16'h0000); // HOLD + branch
        tbl[21] = mk(0, 16'h0000, 0, 16'h0003, 1, 0, 0, 16'h0003, 1, 16'h0100); // load, no inc
        tbl[22] = mk(1, 16'h0555, 0, 16'h0003, 0, 0, 0, 16'h0003, 1, 16'h0100); // stray br ignored
        tbl[23] = mk(0, 16'h0000, 0, 16'h0003, 0, 0, 0, 16'h0003, 1, 16'h0100);
        tbl[24] = mk(0, 16'h0000, 1, 16'h0100, 0, 0, 0, 16'h0003, 1, 16'h0100); // FETCH 0x100
        tbl[25] = mk(0, 16'h0000, 0, 16'h0100, 0, 0, 1, 16'h0100, 1, 16'h0100);

        rst_n = 1'b0; run = 1'b0; halt_req = 1'b0; restart = 1'b0;
        ir_ready = 1'b0; br_valid = 1'b0; br_target = 16'h0000;
        ack_en = 1'b1; ack_delay = 0;

        repeat (3) @(negedge clk);
        chk("rst_ctrl", {rom_req, pc_load, pc_inc, ir_valid, halted, busy, fault}, 0);
        chk("rst_ir", ir, 16'h0000);
        chk("rst_ir_pc", ir_pc, 16'h0000);
        chk("rst_rom_addr", rom_addr, 16'h0000);
        chk("rst_pc_target", pc_target, 16'h0000);

        rst_n = 1'b1;
        run = 1'b1;
        ir_ready = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i > 0) @(negedge clk);
            br_valid  = tbl[i].bv;
            br_target = tbl[i].bt;
            chk($sformatf("row%0d_rom_req", i), rom_req, tbl[i].rreq);
            chk($sformatf("row%0d_rom_addr", i), rom_addr, tbl[i].raddr);
            chk($sformatf("row%0d_pc_ctl", i), {pc_load, pc_inc}, {tbl[i].pld, tbl[i].pinc});
            chk($sformatf("row%0d_ir_valid", i), ir_valid, tbl[i].irv);
            chk($sformatf("row%0d_ir_pc", i), ir_pc, tbl[i].irpc);
            chk($sformatf("row%0d_busy", i), busy, tbl[i].bsy);
            chk($sformatf("row%0d_pc_target", i), pc_target, tbl[i].ptgt);
            if (tbl[i].irv)
                chk($sformatf("row%0d_ir", i), ir, tbl[i].irpc ^ 16'hBEEF);
        end
        @(negedge clk);
        br_valid = 1'b0;

        // Backpressure at 0x0101
        ir_ready = 1'b0;
        wait_on(1, 20, "bp_wait_hold");
        chk("bp_ir_pc", ir_pc, 16'h0101);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_ir_valid", ir_valid, 1'b1);
            chk("bp_ir", ir, 16'h0101 ^ 16'hBEEF);
            chk("bp_ir_pc_stable", ir_pc, 16'h0101);
            chk("bp_no_activity", {pc_load, pc_inc, rom_req}, 3'b000);
        end
        ir_ready = 1'b1;
        n_inc = 0; n_ld = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (pc_inc) n_inc++;
            if (pc_load) n_ld++;
        end
        chk("bp_one_inc", n_inc, 1);
        chk("bp_no_load", n_ld, 0);
        chk("bp_next_req", rom_req, 1'b1);
        chk("bp_next_addr", rom_addr, 16'h0102);

        // Branch to 0xFFFF, then increment wraps to 0x0000
        wait_on(1, 10, "wrap_wait_hold");
        br_valid = 1'b1;
        br_target = 16'hFFFF;
        @(negedge clk);
        br_valid = 1'b0;
        chk("wrap_load", {pc_load, pc_inc}, 2'b10);
        wait_on(0, 10, "wrap_wait_fetch1");
        chk("wrap_addr_ffff", rom_addr, 16'hFFFF);
        wait_on(1, 10, "wrap_wait_hold2");
        chk("wrap_ir_pc", ir_pc, 16'hFFFF);
        @(negedge clk);
        wait_on(0, 10, "wrap_wait_fetch2");
        chk("wrap_addr_0000", rom_addr, 16'h0000);

        // Restart while ROM stalls 4 cycles on the fetch at 0x0001
        @(negedge clk);
        @(negedge clk);
        ack_delay = 4;
        wait_on(0, 10, "rs_wait_fetch");
        chk("rs_fetch_addr", rom_addr, 16'h0001);
        restart = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            restart = 1'b0;
            chk("rs_req_held", rom_req, 1'b1);
            chk("rs_no_ir_valid", ir_valid, 1'b0);
        end
        @(negedge clk);
        chk("rs_clear", {pc_load, pc_inc}, 2'b11);
        chk("rs_ir_valid", ir_valid, 1'b0);
        chk("rs_ir_pc_kept", ir_pc, 16'h0000);
        ack_delay = 0;
        wait_on(0, 10, "rs_wait_refetch");
        chk("rs_refetch_addr", rom_addr, 16'h0000);

        // Halt requested while 0x0007 is held for decode
        g = 0;
        while (!(ir_valid === 1'b1 && ir_pc === 16'h0007) && g < 80) begin
            @(negedge clk);
            g++;
        end
        chk("hl_hold_pc", ir_pc, 16'h0007);
        chk("hl_ir", ir, 16'h0007 ^ 16'hBEEF);
        halt_req = 1'b1;
        rq = 0; g = 0;
        while (halted !== 1'b1 && g < 10) begin
            @(negedge clk);
            g++;
            if (rom_req) rq++;
        end
        chk("hl_halted", halted, 1'b1);
        chk("hl_latency", g, 4);
        chk("hl_no_fetch", rq, 0);
        chk("hl_pc", pc_model, 16'h0008);
        repeat (3) @(negedge clk);
        chk("hl_still_halted", {halted, busy}, 2'b10);
        halt_req = 1'b0;
        wait_on(0, 5, "hl_wait_resume");
        chk("hl_resume_addr", rom_addr, 16'h0008);
        chk("hl_resume_halted", halted, 1'b0);

`ifdef FETCH_CTRL_TIMEOUT_EN
        // Current FETCH at 0x0008 never receives an ack
        ack_en = 1'b0;
        repeat (63) @(negedge clk);
        chk("to_cycle64_req", {rom_req, fault}, 2'b10);
        @(negedge clk);
        chk("to_fault", {rom_req, fault}, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("to_reset_clears", fault, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
